counter_cmd_sequencer: RTL and testbench

Command-driven controller for the 8-bit up/down counter. Accepts one command at a time (load, count up N, count down N, wait N) over a valid/ready handshake. Drives the counter's mode and load-data inputs cycle by cycle, observes its output, and reports completion with the final value and a wrap flag. It sits between a host/test agent and the counter, so nothing else toggles the counter mode directly.

---
 rtl/counter_pkg.sv | 34 +++
 rtl/counter_cmd_sequencer.sv | 126 ++++++++++++
 tb/tb_counter_cmd_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the 8-bit up/down counter and its command sequencer.
package counter_pkg;

    // Default counter data width.
    localparam int COUNTER_WIDTH = 8;

    // Counter mode select, as seen on the counter's s_in input.
    typedef enum logic [1:0] {
        HOLD      = 2'b00,
        INCREMENT = 2'b01,
        DECREMENT = 2'b10,
        LOAD      = 2'b11
    } mode_e;

    // Sequencer command opcodes.
    typedef enum logic [1:0] {
        WAIT    = 2'b00,
        UP      = 2'b01,
        DOWN    = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    // Counter mode to drive during the stepping phase of a command.
    function automatic mode_e step_mode(input op_e op);
        mode_e m;
        case (op)
            UP:      m = INCREMENT;
            DOWN:    m = DECREMENT;
            default: m = HOLD;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/counter_cmd_sequencer.sv
// Command sequencer for the up/down counter: accepts one LOAD/UP/DOWN/WAIT
// command at a time, drives the counter mode cycle by cycle and reports the
// final count plus a wrap flag with a one-cycle done pulse.
module counter_cmd_sequencer
    import counter_pkg::*;
#(
    parameter int WIDTH  = COUNTER_WIDTH,
    parameter int STEP_W = 8,
    parameter int ARG_W  = (WIDTH > STEP_W) ? WIDTH : STEP_W
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [ARG_W-1:0] cmd_arg,
    output logic [1:0]       mode_out,
    output logic [WIDTH-1:0] data_out,
    input  logic [WIDTH-1:0] count_in,
    output logic             busy,
    output logic             done,
    output logic             wrapped,
    output logic [WIDTH-1:0] last_value
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_STEP = 2'b10,
        S_DONE = 2'b11
    } state_e;

    state_e              state_r;
    op_e                 op_r;
    mode_e               mode_r;
    logic [WIDTH-1:0]    data_r;
    logic [STEP_W-1:0]   remaining_r;
    logic                wrap_flag_r;
    logic                done_r;
    logic                wrapped_r;
    logic [WIDTH-1:0]    last_r;

    logic [STEP_W-1:0]   step_arg_s;
    logic                wrap_hit_s;

    assign step_arg_s = cmd_arg[STEP_W-1:0];

    // A step wraps when UP sees all-ones or DOWN sees zero before the edge.
    assign wrap_hit_s = ((op_r == UP)   && (count_in == {WIDTH{1'b1}})) ||
                        ((op_r == DOWN) && (count_in == {WIDTH{1'b0}}));

    // Main FSM: command acceptance, per-cycle mode drive and completion report.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_r     <= S_IDLE;
            op_r        <= WAIT;
            mode_r      <= HOLD;
            data_r      <= {WIDTH{1'b0}};
            remaining_r <= {STEP_W{1'b0}};
            wrap_flag_r <= 1'b0;
            done_r      <= 1'b0;
            wrapped_r   <= 1'b0;
            last_r      <= {WIDTH{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_r        <= op_e'(cmd_op);
                        remaining_r <= step_arg_s;
                        wrap_flag_r <= 1'b0;
                        if (op_e'(cmd_op) == OP_LOAD) begin
                            state_r <= S_LOAD;
                            mode_r  <= LOAD;
                            data_r  <= cmd_arg[WIDTH-1:0];
                        end else if (step_arg_s == {STEP_W{1'b0}}) begin
                            // Zero-length step command completes immediately.
                            state_r <= S_DONE;
                            mode_r  <= HOLD;
                        end else begin
                            state_r <= S_STEP;
                            mode_r  <= step_mode(op_e'(cmd_op));
                        end
                    end else begin
                        mode_r <= HOLD;
                    end
                end
                S_LOAD: begin
                    state_r <= S_DONE;
                    mode_r  <= HOLD;
                end
                S_STEP: begin
                    if (wrap_hit_s) begin
                        wrap_flag_r <= 1'b1;
                    end
                    remaining_r <= remaining_r - STEP_W'(1);
                    // The edge leaving the last STEP cycle is the Nth counter edge.
                    if (remaining_r == STEP_W'(1)) begin
                        state_r <= S_DONE;
                        mode_r  <= HOLD;
                    end
                end
                S_DONE: begin
                    state_r   <= S_IDLE;
                    mode_r    <= HOLD;
                    done_r    <= 1'b1;
                    wrapped_r <= wrap_flag_r;
                    last_r    <= count_in;
                end
                default: begin
                    state_r <= S_IDLE;
                    mode_r  <= HOLD;
                end
            endcase
        end
    end

    assign cmd_ready  = (state_r == S_IDLE);
    assign busy       = (state_r != S_IDLE);
    assign mode_out   = mode_r;
    assign data_out   = data_r;
    assign done       = done_r;
    assign wrapped    = wrapped_r;
    assign last_value = last_r;

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Self-checking bench for counter_cmd_sequencer with a behavioural counter
// attached and a command-level reference model.
module tb_counter_cmd_sequencer;
    import counter_pkg::*;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_arg;
    logic [1:0] mode_out;
    logic [7:0] data_out;
    logic [7:0] count_in;
    logic       busy;
    logic       done;
    logic       wrapped;
    logic [7:0] last_value;

    int n_checks = 0;
    int n_fail   = 0;

    counter_cmd_sequencer dut (
        .clk_in(clk_in), .reset_in(reset_in), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .mode_out(mode_out), .data_out(data_out), .count_in(count_in),
        .busy(busy), .done(done), .wrapped(wrapped), .last_value(last_value)
    );

    always #5 clk_in = ~clk_in;

    // Behavioural 8-bit up/down counter driven by the sequencer.
    always @(posedge clk_in) begin
        if (reset_in) count_in <= 8'd0;
        else begin
            case (mode_out)
                2'b01:   count_in <= count_in + 8'd1;
                2'b10:   count_in <= count_in - 8'd1;
                2'b11:   count_in <= data_out;
                default: count_in <= count_in;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model state (command level)
    int         cyc = 0;
    bit         armed = 0;
    bit         in_flight = 0;
    int         h = 0, d_off = 0, m_len = 0;
    logic [1:0] m_mode = 2'b00;
    int         m_val = 0, m_last = 0, m_data = 0;
    bit         m_wrap = 0;
    int         hs_cnt = 0, done_cnt = 0, done_cyc = 0, hs_cyc = 0;
    int         done_val = 0;
    logic       done_wrap = 1'b0;
    int         inc_cycles = 0, load_cycles = 0, active_cycles = 0;

    // Per-cycle comparison against the model, then model update for the next edge.
    initial begin
        int k, n, a;
        bit e_busy, e_done;
        logic [1:0] em;
        forever begin
            @(negedge clk_in);
            cyc++;
            k = cyc - h;
            e_busy = in_flight && (k < d_off);
            e_done = in_flight && (k == d_off);
            if (armed) begin
                em = (in_flight && k < m_len) ? m_mode : 2'b00;
                chk("mode_out", mode_out, em);
                chk("cmd_ready", cmd_ready, !e_busy);
                chk("busy", busy, e_busy);
                chk("done", done, e_done);
                chk("last_value", last_value, e_done ? m_val : m_last);
                chk("data_out", data_out, m_data);
                if (e_done) chk("wrapped", wrapped, m_wrap);
            end
            if (done === 1'b1) begin
                done_cnt++; done_cyc = cyc; done_val = last_value; done_wrap = wrapped;
            end
            if (mode_out == 2'b01) inc_cycles++;
            if (mode_out == 2'b11) load_cycles++;
            if (mode_out != 2'b00) active_cycles++;
            if (e_done) begin
                in_flight = 0;
                m_last = m_val;
            end
            if (reset_in === 1'b1) begin
                armed = 1; in_flight = 0; m_val = 0; m_last = 0; m_data = 0;
            end else if (armed && cmd_valid && !e_busy) begin
                a = cmd_arg;
                hs_cnt++; h = cyc + 1; hs_cyc = h; in_flight = 1;
                if (cmd_op == 2'b11) begin
                    d_off = 2; m_len = 1; m_mode = 2'b11; m_val = a; m_wrap = 0; m_data = a;
                end else begin
                    n = a;
                    d_off = n + 1; m_len = n; m_mode = cmd_op; m_wrap = 0;
                    if (cmd_op == 2'b01) begin
                        m_wrap = (m_val + n) > 255;
                        m_val = (m_val + n) % 256;
                    end else if (cmd_op == 2'b10) begin
                        m_wrap = n > m_val;
                        m_val = (m_val - n + 256) % 256;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_in); #1;
    endtask

    task automatic wait_hs(input int start);
        int t = 0;
        while (hs_cnt == start && t < 400) begin step(); t++; end
        if (hs_cnt == start) begin
            n_checks++; n_fail++;
            $display("FAIL handshake_timeout: no handshake after %0d cycles", t);
        end
    endtask

    task automatic wait_done(input int start);
        int t = 0;
        while (done_cnt == start && t < 400) begin step(); t++; end
        if (done_cnt == start) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: no done after %0d cycles", t);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] arg);
        int s;
        s = hs_cnt;
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        wait_hs(s);
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_arg = 8'($urandom);
    endtask

    task automatic run(input logic [1:0] op, input logic [7:0] arg);
        int d;
        d = done_cnt;
        issue(op, arg);
        wait_done(d);
    endtask

    initial begin
        int i0, a0, d0, s0, up_done, gap, n;
        logic [1:0] op;
        logic [7:0] arg;
        reset_in = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 8'd0;
        repeat (3) step();
        reset_in = 1'b0;
        step();
        chk("rst_ready", cmd_ready, 1);
        chk("rst_mode", mode_out, 0);
        chk("rst_last", last_value, 0);
        chk("rst_data", data_out, 0);

        // LOAD 200
        i0 = load_cycles;
        run(2'b11, 8'd200);
        chk("lit_load200_val", done_val, 200);
        chk("lit_load200_wrap", done_wrap, 0);
        chk("lit_load200_lat", done_cyc - hs_cyc, 2);
        chk("lit_load200_modecyc", load_cycles - i0, 1);

        // LOAD 245, UP 20 with a different command held valid during STEP
        run(2'b11, 8'd245);
        i0 = inc_cycles; d0 = done_cnt; s0 = hs_cnt;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_arg = 8'd20;
        wait_hs(s0);
        s0 = hs_cnt;
        cmd_op = 2'b10; cmd_arg = 8'd3;
        wait_done(d0);
        up_done = done_cyc;
        chk("lit_up20_val", done_val, 9);
        chk("lit_up20_wrap", done_wrap, 1);
        chk("lit_up20_inc", inc_cycles - i0, 20);
        d0 = done_cnt;
        wait_hs(s0);
        chk("lit_held_hs", hs_cyc - up_done, 1);
        cmd_valid = 1'b0;
        wait_done(d0);
        chk("lit_down3_val", done_val, 6);
        chk("lit_down3_wrap", done_wrap, 0);

        // DOWN through zero
        run(2'b11, 8'd0);
        run(2'b10, 8'd1);
        chk("lit_down1_val", done_val, 255);
        chk("lit_down1_wrap", done_wrap, 1);
        run(2'b10, 8'd5);
        chk("lit_down5_val", done_val, 250);
        chk("lit_down5_wrap", done_wrap, 0);

        // WAIT and zero-length UP
        run(2'b11, 8'd45);
        a0 = active_cycles;
        run(2'b00, 8'd10);
        chk("lit_wait_lat", done_cyc - hs_cyc, 11);
        chk("lit_wait_val", done_val, 45);
        chk("lit_wait_hold", active_cycles - a0, 0);
        run(2'b01, 8'd0);
        chk("lit_up0_lat", done_cyc - hs_cyc, 1);
        chk("lit_up0_val", done_val, 45);
        chk("lit_up0_wrap", done_wrap, 0);

        // Reset in the middle of UP 100
        run(2'b11, 8'd0);
        d0 = done_cnt;
        issue(2'b01, 8'd100);
        repeat (29) step();
        reset_in = 1'b1;
        step();
        reset_in = 1'b0;
        chk("lit_rst_mode", mode_out, 0);
        chk("lit_rst_ready", cmd_ready, 1);
        repeat (5) step();
        chk("lit_rst_nodone", done_cnt, d0);

        // Randomized commands, gaps, held-valid chaining and argument noise
        for (int c = 0; c < 60; c++) begin
            op = 2'($urandom);
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
            if ($urandom_range(0, 7) == 0) n = 0;
            arg = 8'(n);
            if ($urandom_range(0, 3) == 0) begin
                s0 = hs_cnt;
                cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
                wait_hs(s0);
            end else begin
                issue(op, arg);
                gap = $urandom_range(0, 4);
                for (int g = 0; g < gap; g++) begin
                    cmd_op = 2'($urandom); cmd_arg = 8'($urandom);
                    step();
                end
            end
        end
        cmd_valid = 1'b0;
        d0 = 0;
        while (in_flight && d0 < 400) begin step(); d0++; end
        chk("final_idle", in_flight, 0);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
